// File: rtl/mod_keygen_subword.sv
// AES-256 key-expansion word generator placed after the RotWord shifter.
// Builds w[i] = SubWord(in_word) ^ Rcon ^ w[i-8]. The four S-box lookups share
// one external combinational S-box port, one byte per cycle.
// Both sides use a valid/ready handshake, and only one word is in flight at a time.
module mod_keygen_subword #(
  parameter int NB = 4,
  parameter int BW = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NB-1:0][BW-1:0]  in_word,
  input  logic [NB-1:0][BW-1:0]  prev_word,
  input  logic                   rcon_en,
  input  logic [3:0]             rcon_idx,
  output logic [BW-1:0]          sbox_addr,
  input  logic [BW-1:0]          sbox_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NB-1:0][BW-1:0]  out_word
);

  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SUB  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic [NB-1:0][BW-1:0]   word_q;
  logic [NB-1:0][BW-1:0]   prev_q;
  logic [NB-1:0][BW-1:0]   acc;
  logic [BW-1:0]           rcon_q;
  logic [7:0]              rcon_byte;

  // Round-constant lookup. Indices outside 1..10 quietly give zero.
  always_comb begin
    rcon_byte = 8'h00;
    case (rcon_idx)
      4'd1:    rcon_byte = 8'h01;
      4'd2:    rcon_byte = 8'h02;
      4'd3:    rcon_byte = 8'h04;
      4'd4:    rcon_byte = 8'h08;
      4'd5:    rcon_byte = 8'h10;
      4'd6:    rcon_byte = 8'h20;
      4'd7:    rcon_byte = 8'h40;
      4'd8:    rcon_byte = 8'h80;
      4'd9:    rcon_byte = 8'h1B;
      4'd10:   rcon_byte = 8'h36;
      default: rcon_byte = 8'h00;
    endcase
  end

  // Sequencing: accept a word, walk the four bytes through the S-box, then hold the result until it is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state <= ST_SUB;
            cnt   <= '0;
          end
        end
        ST_SUB: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Input capture happens only on the accepting edge, so upstream may change its inputs afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_q <= '0;
      prev_q <= '0;
      rcon_q <= '0;
    end else if (state == ST_IDLE && in_valid) begin
      word_q <= in_word;
      prev_q <= prev_word;
      rcon_q <= rcon_en ? BW'(rcon_byte) : '0;
    end
  end

  // Result bytes are built one per SUB cycle. Rcon is folded only into the leading byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (state == ST_SUB) begin
      acc[cnt] <= sbox_data ^ prev_q[cnt] ^ ((cnt == '0) ? rcon_q : '0);
    end
  end

  // The S-box address is parked at zero outside SUB, so the shared S-box sees a quiet bus.
  always_comb begin
    sbox_addr = '0;
    if (state == ST_SUB) begin
      sbox_addr = word_q[cnt];
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_OUT);
  assign out_word  = acc;

endmodule

// File: tb/tb_mod_keygen_subword.sv
// Self-checking bench for mod_keygen_subword.
// The bench drives FIPS-197 vectors, backpressure, out-of-range Rcon indices, a mid-word reset and randomized streams.
// Its S-box and its reference w[i] are both computed from GF(2^8) arithmetic.
module tb_mod_keygen_subword;

  typedef logic [3:0][7:0] word_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  word_t       in_word;
  word_t       prev_word;
  logic        rcon_en;
  logic [3:0]  rcon_idx;
  logic [7:0]  sbox_addr;
  logic [7:0]  sbox_data;
  logic        out_valid;
  logic        out_ready;
  word_t       out_word;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sbox_tab [256];
  word_t      exp_q [$];

  mod_keygen_subword #(.NB(4), .BW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .prev_word (prev_word),
    .rcon_en   (rcon_en),
    .rcon_idx  (rcon_idx),
    .sbox_addr (sbox_addr),
    .sbox_data (sbox_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word)
  );

  assign sbox_data = sbox_tab[sbox_addr];

  // Free-running 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog that guarantees the run terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = xtime(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b};
    return t[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    if (a != 8'h00) begin
      for (int c = 1; c < 256; c++) begin
        if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    if (idx >= 4'd1 && idx <= 4'd10) begin
      r = 8'h01;
      for (int k = 1; k < int'(idx); k++) r = xtime(r);
    end
    return r;
  endfunction

  function automatic word_t model_word(input word_t w, input word_t p, input logic en, input logic [3:0] idx);
    word_t e;
    for (int k = 0; k < 4; k++) e[k] = sbox_ref(w[k]) ^ p[k];
    if (en) e[0] = e[0] ^ rcon_ref(idx);
    return e;
  endfunction

  function automatic word_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    word_t w;
    w[0] = b0;
    w[1] = b1;
    w[2] = b2;
    w[3] = b3;
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Performs one directed transaction, starting and ending just after a falling edge with the DUT idle.
  task automatic applyStimulus(input word_t w, input word_t p, input logic en, input logic [3:0] idx,
                               input int hold, input word_t exp);
    word_t held;
    in_valid  = 1'b1;
    in_word   = w;
    prev_word = p;
    rcon_en   = en;
    rcon_idx  = idx;
    out_ready = (hold == 0);
    checkOutput("idle_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    in_word   = word_t'($urandom);
    prev_word = word_t'($urandom);
    rcon_en   = 1'($urandom);
    rcon_idx  = 4'($urandom);
    for (int j = 0; j < 4; j++) begin
      checkOutput("sub_addr", 32'(sbox_addr), 32'(w[j]));
      checkOutput("sub_busy", {30'd0, in_ready, out_valid}, 32'd0);
      @(negedge clk);
    end
    checkOutput("out_valid_rise", 32'(out_valid), 32'd1);
    checkOutput("out_word", out_word, exp);
    if (hold > 0) begin
      held = out_word;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_word", out_word, held);
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        checkOutput("hold_addr", 32'(sbox_addr), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    checkOutput("released_valid", 32'(out_valid), 32'd0);
    checkOutput("released_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  // Streams n random words into the DUT and queues each reference result on its accepting edge
  task automatic drive_stream(input int n, input bit b2b, input int budget);
    word_t w;
    word_t p;
    logic  en;
    logic [3:0] idx;
    logic  r;
    int    spent;
    spent = 0;
    for (int i = 0; i < n; i++) begin
      if (!b2b) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) begin
          in_word   = word_t'($urandom);
          prev_word = word_t'($urandom);
          @(negedge clk);
        end
      end
      w   = word_t'($urandom);
      p   = word_t'($urandom);
      en  = 1'($urandom);
      idx = 4'($urandom);
      in_valid  = 1'b1;
      in_word   = w;
      prev_word = p;
      rcon_en   = en;
      rcon_idx  = idx;
      r = 1'b0;
      while (!r && spent < budget) begin
        r = in_ready;
        @(posedge clk);
        if (r) exp_q.push_back(model_word(w, p, en, idx));
        @(negedge clk);
        spent++;
        if (!b2b) begin
          in_word   = r ? word_t'($urandom) : w;
          prev_word = r ? word_t'($urandom) : p;
        end
      end
      if (!r) begin
        checkOutput("stream_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Consumes outputs, compares them against the queue in order and checks spacing and hold stability
  task automatic monitor_stream(input int n, input bit bp, input bit check_spacing, input int budget);
    int    got;
    int    iter;
    int    last_xfer;
    bit    holding;
    word_t held;
    word_t expw;
    got       = 0;
    iter      = 0;
    last_xfer = -1;
    holding   = 1'b0;
    held      = '0;
    while (got < n && iter < budget) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (holding) begin
        checkOutput("stream_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("stream_hold_word", out_word, held);
      end
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("stream_spurious", 32'd1, 32'd0);
          end else begin
            expw = exp_q.pop_front();
            checkOutput("stream_word", out_word, expw);
          end
          if (check_spacing && last_xfer >= 0) checkOutput("stream_spacing", 32'(iter - last_xfer), 32'd6);
          last_xfer = iter;
          got++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held    = out_word;
        end
      end
      @(negedge clk);
      iter++;
    end
    checkOutput("stream_count", 32'(got), 32'(n));
    out_ready = 1'b0;
  endtask

  // Main test sequence
  initial begin
    for (int a = 0; a < 256; a++) sbox_tab[a] = sbox_ref(8'(a));
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_word   = '0;
    prev_word = '0;
    rcon_en   = 1'b0;
    rcon_idx  = 4'd0;
    out_ready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_word", out_word, 32'd0);
    checkOutput("reset_addr", 32'(sbox_addr), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", 32'(in_ready), 32'd1);

    $display("[TB] case 1: FIPS-197 w8");
    applyStimulus(mk(8'h14, 8'hdf, 8'hf4, 8'h09), mk(8'h60, 8'h3d, 8'heb, 8'h10), 1'b1, 4'd1, 0,
                  mk(8'h9b, 8'ha3, 8'h54, 8'h11));

    $display("[TB] case 2: FIPS-197 w12");
    applyStimulus(mk(8'h20, 8'h67, 8'hfc, 8'hde), mk(8'h1f, 8'h35, 8'h2c, 8'h07), 1'b0, 4'd1, 0,
                  mk(8'ha8, 8'hb0, 8'h9c, 8'h1a));

    $display("[TB] case 3: backpressure");
    applyStimulus(mk(8'h14, 8'hdf, 8'hf4, 8'h09), mk(8'h60, 8'h3d, 8'heb, 8'h10), 1'b1, 4'd1, 10,
                  mk(8'h9b, 8'ha3, 8'h54, 8'h11));

    $display("[TB] case 4: out-of-range rcon index");
    applyStimulus('0, '0, 1'b1, 4'd0, 0, mk(8'h63, 8'h63, 8'h63, 8'h63));
    applyStimulus('0, '0, 1'b1, 4'd12, 0, mk(8'h63, 8'h63, 8'h63, 8'h63));
    applyStimulus('0, '0, 1'b1, 4'd10, 0, mk(8'h55, 8'h63, 8'h63, 8'h63));

    $display("[TB] case 5: reset during SUB");
    in_valid  = 1'b1;
    in_word   = mk(8'h14, 8'hdf, 8'hf4, 8'h09);
    prev_word = mk(8'h60, 8'h3d, 8'heb, 8'h10);
    rcon_en   = 1'b1;
    rcon_idx  = 4'd1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_reset_addr_before", 32'(sbox_addr), 32'h000000f4);
    rst = 1'b0;
    #1;
    checkOutput("mid_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_reset_out_word", out_word, 32'd0);
    checkOutput("mid_reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_reset_addr", 32'(sbox_addr), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_reset_no_output", 32'(out_valid), 32'd0);
    applyStimulus(mk(8'h20, 8'h67, 8'hfc, 8'hde), mk(8'h1f, 8'h35, 8'h2c, 8'h07), 1'b0, 4'd1, 0,
                  mk(8'ha8, 8'hb0, 8'h9c, 8'h1a));

    $display("[TB] case 6: back-to-back words");
    exp_q.delete();
    fork
      drive_stream(3, 1'b1, 100);
      monitor_stream(3, 1'b0, 1'b1, 100);
    join
    checkOutput("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] case 7: randomized stream with backpressure");
    @(negedge clk);
    exp_q.delete();
    fork
      drive_stream(25, 1'b0, 2000);
      monitor_stream(25, 1'b1, 1'b0, 2000);
    join
    checkOutput("random_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
